// File: rtl/decode_stage.sv
// ID stage: decodes the IF/ID instruction, reads operands, detects
// load-use hazards and loads the ID/EX register consumed by EX.
module decode_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [DATA_W-1:0]  if_instr,
  input  logic [DATA_W-1:0]  if_pc,
  input  logic               flush,
  output logic               stall_out,
  output logic [RADDR_W-1:0] rf_src1,
  output logic [RADDR_W-1:0] rf_src2,
  input  logic [DATA_W-1:0]  rf_data1,
  input  logic [DATA_W-1:0]  rf_data2,
  output logic               ex_valid,
  output logic [3:0]         ex_opcode,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [RADDR_W-1:0] ex_src1,
  output logic [RADDR_W-1:0] ex_src2,
  output logic [DATA_W-1:0]  ex_a,
  output logic [DATA_W-1:0]  ex_b,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_pc,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               halted,
  output logic [15:0]        stall_count
);

  typedef struct packed {
    logic               valid;
    logic [3:0]         op;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] s1;
    logic [RADDR_W-1:0] s2;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc;
    logic               rw;
    logic               mr;
    logic               mw;
  } idex_t;

  idex_t       dec;
  idex_t       idex_q, idex_d;
  logic        halted_q, halted_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hit1, hit2, hazard, load;

  logic [3:0]         op;
  logic [RADDR_W-1:0] f1, f2, f3;

  assign op = if_instr[15:12];
  assign f1 = if_instr[11:8];
  assign f2 = if_instr[7:4];
  assign f3 = if_instr[3:0];

  always_comb begin
    dec    = '0;
    dec.op = op;
    unique case (1'b1)
      !op[3]: begin
        dec.rd = f1;
        dec.s1 = f2;
        dec.s2 = f3;
        dec.rw = 1'b1;
      end
      op == 4'h8: begin
        dec.rd  = f1;
        dec.s1  = f2;
        dec.imm = {{(DATA_W-5){f3[3]}}, f3, 1'b0};
        dec.rw  = 1'b1;
        dec.mr  = 1'b1;
      end
      op == 4'h9: begin
        dec.s1  = f2;
        dec.s2  = f1;
        dec.imm = {{(DATA_W-5){f3[3]}}, f3, 1'b0};
        dec.mw  = 1'b1;
      end
      op == 4'hA || op == 4'hB: begin
        dec.rd  = f1;
        dec.s1  = f1;
        dec.imm = {{(DATA_W-8){1'b0}}, if_instr[7:0]};
        dec.rw  = 1'b1;
      end
      op == 4'hC: begin
        dec.imm = {{(DATA_W-10){if_instr[8]}}, if_instr[8:0], 1'b0};
      end
      op == 4'hD: begin
        dec.s1 = f2;
      end
      op == 4'hE: begin
        dec.rd = f1;
        dec.rw = 1'b1;
      end
      default: ;
    endcase
    // Writes to r0 are architecturally discarded
    if (dec.rd == '0) dec.rw = 1'b0;
  end

  assign rf_src1 = dec.s1;
  assign rf_src2 = dec.s2;

  assign hit1 = (dec.s1 != '0) && (dec.s1 == idex_q.rd);
  assign hit2 = (dec.s2 != '0) && (dec.s2 == idex_q.rd);

  assign hazard = idex_q.valid && idex_q.mr && (idex_q.rd != '0) &&
                  if_valid && !halted_q && (hit1 || hit2);

  assign stall_out = hazard && !flush;
  assign load = !(flush || hazard || !if_valid || halted_q);

  always_comb begin
    idex_d   = '0;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (stall_out && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    if (load) begin
      idex_d       = dec;
      idex_d.valid = 1'b1;
      idex_d.a     = rf_data1;
      idex_d.b     = rf_data2;
      idex_d.pc    = if_pc;
      if (op == 4'hF) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q   <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      idex_q   <= idex_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_opcode    = idex_q.op;
  assign ex_rd        = idex_q.rd;
  assign ex_src1      = idex_q.s1;
  assign ex_src2      = idex_q.s2;
  assign ex_a         = idex_q.a;
  assign ex_b         = idex_q.b;
  assign ex_imm       = idex_q.imm;
  assign ex_pc        = idex_q.pc;
  assign ex_reg_write = idex_q.rw;
  assign ex_mem_read  = idex_q.mr;
  assign ex_mem_write = idex_q.mw;
  assign halted       = halted_q;
  assign stall_count  = cnt_q;

endmodule
